// File: rtl/matrix_result_fifo_if.sv
// Shared matrix bus as seen by one responder.
//   DataOut  : responder read data toward the top-level read mux
//   DataIn   : write data from the execution unit
//   address  : bus address, [15:12] selects the device
//   nRead    : active-low read strobe
//   nWrite   : active-low write strobe
// Modports: master (execution unit side), slave (responder side).
interface matrix_result_fifo_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 16
);
  logic [DATA_W-1:0] DataOut;
  logic [DATA_W-1:0] DataIn;
  logic [ADDR_W-1:0] address;
  logic              nRead;
  logic              nWrite;

  modport master (output DataIn, address, nRead, nWrite, input DataOut);
  modport slave  (input DataIn, address, nRead, nWrite, output DataOut);
endinterface

// File: rtl/matrix_result_fifo.sv
// Memory-mapped FIFO of matrix words on the shared matrix bus.
// Writing DATA pushes a word, reading DATA pops one; STATUS reports
// occupancy plus sticky OVF/UNF/COLL flags (write-1-to-clear).
//   Clk     : rising-edge clock
//   nReset  : asynchronous active-low reset
//   bus     : slave side of the matrix bus (DataIn/address/nRead/nWrite in,
//             DataOut out, registered, one cycle read latency)
// Offsets: 0x000 DATA, 0x001 STATUS; others read as zero, writes ignored.
module matrix_result_fifo #(
  parameter int         DATA_W  = 256,
  parameter int         ADDR_W  = 16,
  parameter logic [3:0] BASE_ID = 4'hC,
  parameter int         DEPTH   = 8
) (
  input  logic                 Clk,
  input  logic                 nReset,
  matrix_result_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     count;
  logic [2:0]        flags;      // {COLL, UNF, OVF}
  logic              rdPrev, wrPrev;

  logic              sel, isData, isStat;
  logic              rdGo, wrGo, coll, doRd, doWr;
  logic              full, empty, push, pop;
  logic [2:0]        flagSet, flagClr;
  logic [DATA_W-1:0] statusWord, rdData;

  assign sel    = (bus.address[ADDR_W-1 -: 4] == BASE_ID);
  assign isData = (bus.address[11:0] == 12'h000);
  assign isStat = (bus.address[11:0] == 12'h001);

  // One operation per strobe: only the high-to-low transition fires.
  assign rdGo = sel & ~bus.nRead  & rdPrev;
  assign wrGo = sel & ~bus.nWrite & wrPrev;
  assign coll = rdGo & wrGo;
  assign doRd = rdGo & ~wrGo;
  assign doWr = wrGo & ~rdGo;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = doWr & isData & ~full;
  assign pop   = doRd & isData & ~empty;

  assign flagSet = {coll, doRd & isData & empty, doWr & isData & full};
  assign flagClr = (doWr & isStat) ? bus.DataIn[12:10] : 3'b000;

  always_comb begin
    statusWord       = '0;
    statusWord[12:0] = {flags, full, empty, 8'(count)};
  end

  always_comb begin
    rdData = '0;
    if (isData && !empty) rdData = mem[rp];
    else if (isStat)      rdData = statusWord;
  end

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge Clk) begin
    if (push) mem[wp] <= bus.DataIn;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      flags       <= '0;
      rdPrev      <= 1'b1;
      wrPrev      <= 1'b1;
      bus.DataOut <= '0;
    end else begin
      rdPrev <= bus.nRead;
      wrPrev <= bus.nWrite;
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      if (push)     count <= count + CW'(1);
      else if (pop) count <= count - CW'(1);
      // Set dominates clear on the same edge.
      flags <= (flags & ~flagClr) | flagSet;
      // Read data is held while the strobe stays low and selected.
      if (coll)                       bus.DataOut <= '0;
      else if (doRd)                  bus.DataOut <= rdData;
      else if (bus.nRead || !sel)     bus.DataOut <= '0;
    end
  end
endmodule

// File: tb/tb_matrix_result_fifo.sv
module tb_matrix_result_fifo;
  localparam int DW = 256;
  localparam int AW = 16;
  localparam int DEPTH = 8;

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  always #5 Clk = ~Clk;

  matrix_result_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  matrix_result_fifo #(.DATA_W(DW), .ADDR_W(AW), .BASE_ID(4'hC), .DEPTH(DEPTH)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus)
  );

  // Reference model: a plain queue and three sticky bits.
  logic [DW-1:0] q [$];
  bit ovf, unf, coll;

  // Scoreboard of DataOut values expected after the next rising edge.
  logic [DW-1:0] sb [$];
  bit pendRd = 0;
  int compared = 0;
  int mism = 0;

  function automatic logic [DW-1:0] mStatus();
    logic [DW-1:0] s;
    s = '0;
    s[7:0] = 8'(q.size());
    s[8]   = (q.size() == 0);
    s[9]   = (q.size() == DEPTH);
    s[10]  = ovf;
    s[11]  = unf;
    s[12]  = coll;
    return s;
  endfunction

  function automatic logic [DW-1:0] mRead(logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    if (a[15:12] != 4'hC) return r;
    if (a[11:0] == 12'h000) begin
      if (q.size() > 0) r = q.pop_front();
      else unf = 1;
    end else if (a[11:0] == 12'h001) begin
      r = mStatus();
    end
    return r;
  endfunction

  function automatic void mWrite(logic [AW-1:0] a, logic [DW-1:0] d);
    if (a[15:12] != 4'hC) return;
    if (a[11:0] == 12'h000) begin
      if (q.size() < DEPTH) q.push_back(d);
      else ovf = 1;
    end else if (a[11:0] == 12'h001) begin
      if (d[10]) ovf = 0;
      if (d[11]) unf = 0;
      if (d[12]) coll = 0;
    end
  endfunction

  function automatic logic [DW-1:0] rndWord();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: whatever the stimulus expected for this edge is popped and compared.
  always @(posedge Clk) begin
    #1;
    if (pendRd) begin
      pendRd = 0;
      if (sb.size() == 0) begin
        compared++;
        mism++;
        $display("FAIL scoreboard: DataOut %0h with no expected entry", bus.DataOut);
      end else begin
        check("DataOut", bus.DataOut, sb.pop_front());
      end
    end
  end

  task automatic expectNext(logic [DW-1:0] v);
    sb.push_back(v);
    pendRd = 1;
    @(negedge Clk);
  endtask

  // Strobe low for 'hold' cycles, then high; DataOut checked every edge.
  task automatic doRead(logic [AW-1:0] a, int hold);
    logic [DW-1:0] e;
    bus.address = a;
    bus.nRead   = 0;
    e = mRead(a);
    for (int i = 0; i < hold; i++) expectNext(e);
    bus.nRead = 1;
    expectNext('0);
  endtask

  task automatic doWrite(logic [AW-1:0] a, logic [DW-1:0] d, int hold);
    bus.address = a;
    bus.DataIn  = d;
    bus.nWrite  = 0;
    mWrite(a, d);
    repeat (hold) @(negedge Clk);
    bus.nWrite = 1;
    @(negedge Clk);
  endtask

  task automatic doColl(logic [AW-1:0] a);
    bus.address = a;
    bus.DataIn  = rndWord();
    bus.nRead   = 0;
    bus.nWrite  = 0;
    coll = 1;
    expectNext('0);
    bus.nRead  = 1;
    bus.nWrite = 1;
    expectNext('0);
  endtask

  task automatic mReset();
    q.delete();
    ovf = 0; unf = 0; coll = 0;
  endtask

  logic [DW-1:0] words [9];

  initial begin
    bus.address = '0;
    bus.DataIn  = '0;
    bus.nRead   = 1;
    bus.nWrite  = 1;
    mReset();
    repeat (2) @(negedge Clk);
    check("reset DataOut", bus.DataOut, '0);
    nReset = 1;
    @(negedge Clk);

    // 1: status after reset
    doRead(16'hC001, 1);

    // 2: three pushes then three pops
    doWrite(16'hC000, 256'hA1, 1);
    doWrite(16'hC000, 256'hA2, 1);
    doWrite(16'hC000, 256'hA3, 1);
    repeat (3) doRead(16'hC000, 1);
    doRead(16'hC001, 1);

    // 3: overflow at DEPTH+1
    for (int i = 0; i < 9; i++) begin
      words[i] = rndWord();
      doWrite(16'hC000, words[i], 1);
    end
    doRead(16'hC001, 1);
    repeat (8) doRead(16'hC000, 1);
    doWrite(16'hC001, 256'h400, 1);

    // 4: underflow then W1C of UNF
    doRead(16'hC000, 1);
    doRead(16'hC001, 1);
    doWrite(16'hC001, 256'h800, 1);
    doRead(16'hC001, 1);

    // 5: held read pops once; collision
    doWrite(16'hC000, rndWord(), 1);
    doWrite(16'hC000, rndWord(), 3);
    doRead(16'hC000, 5);
    doRead(16'hC001, 2);
    doColl(16'hC000);
    doRead(16'hC001, 1);

    // 6: reset mid-strobe, then a strobe held across reset release
    repeat (3) doWrite(16'hC000, rndWord(), 1);
    bus.address = 16'hC000;
    bus.nRead = 0;
    expectNext(mRead(16'hC000));
    #2 nReset = 0;
    mReset();
    #1 check("async reset DataOut", bus.DataOut, '0);
    bus.address = 16'hC001;
    @(negedge Clk);
    nReset = 1;
    expectNext(mStatus());
    bus.nRead = 1;
    expectNext('0);
    doWrite(16'h5000, rndWord(), 1);
    doRead(16'h5000, 2);
    doRead(16'h5001, 1);
    doRead(16'hC001, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      int op, hold;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      op   = $urandom_range(0, 9);
      hold = $urandom_range(1, 3);
      d    = rndWord();
      case (op)
        0, 1, 2: doWrite(16'hC000, d, hold);
        3, 4:    doRead(16'hC000, hold);
        5:       doRead(16'hC001, hold);
        6:       doWrite(16'hC001, d, hold);
        7: begin
          a = 16'(($urandom_range(0, 15) << 12) | $urandom_range(0, 3));
          if ($urandom_range(0, 1) == 1) doRead(a, hold);
          else doWrite(a, d, hold);
        end
        8:       doColl(16'(16'hC000 | $urandom_range(0, 2)));
        default: begin
          bus.address = 16'(16'hC000 | $urandom_range(2, 4095));
          doRead(bus.address, hold);
        end
      endcase
    end
    doRead(16'hC001, 1);

    repeat (2) @(negedge Clk);
    compared++;
    if (sb.size() != 0 || pendRd) begin
      mism++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
